fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Next-generation instruction fetch stage. It owns the PC and issues one request at a time to an
//  instruction memory with variable latency. It buffers returned {pc, instr} pairs in a DEPTH-entry
//  prefetch FIFO, which replaces the single IF/ID register. It sits between imem and decode.
//  Branch redirect flushes the queue and discards any stale in-flight response.
// PARAMETERS
//  ADDR_WIDTH   32          PC / imem address width
//  INSTR_WIDTH  32          instruction word width
//  DEPTH        4           prefetch FIFO entries; power of two, >= 2
//  PC_STEP      4           sequential PC increment
//  RESET_PC     32'h0       fetch PC after reset
// PORTS
//  clock          in   1            single clock, rising edge
//  reset          in   1            synchronous, active-high
//  redirect_valid in   1            branch/jump taken; flush and refetch
//  redirect_pc    in   ADDR_WIDTH   new fetch target
//  imem_req       out  1            request strobe; accepted the same cycle
//  imem_addr      out  ADDR_WIDTH   request address; valid while imem_req
//  imem_rvalid    in   1            response valid; >= 1 cycle after request
//  imem_rdata     in   INSTR_WIDTH  response instruction
//  id_valid       out  1            queue head valid toward decode
//  id_ready       in   1            decode accepts head (low = stall)
//  id_pc          out  ADDR_WIDTH   PC of head instruction
//  id_instr       out  INSTR_WIDTH  head instruction
//  queue_count    out  clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC; FIFO empty; state IDLE; imem_req=0; id_valid=0; queue_count=0;
//    id_pc/id_instr=0. Reset overrides all inputs, including an in-flight response, which is ignored.
//  FSM states:
//   IDLE  no outstanding request.
//   WAIT  one outstanding request; its pc is held in req_pc.
//   DROP  one outstanding request made stale by a redirect.
//  Issue (IDLE only): imem_req=1 and imem_addr=fetch_pc when (queue_count < DEPTH) and !redirect_valid.
//    Same edge: req_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^ADDR_WIDTH), state<=WAIT.
//  WAIT & imem_rvalid: push {req_pc, imem_rdata}; state<=IDLE.
//    No new issue in the same cycle, so peak throughput is 1 instruction per (L+1) cycles.
//  DROP & imem_rvalid: data discarded; state<=IDLE.
//  imem_rvalid in IDLE is ignored, since it is a protocol violation.
//  Pop: when id_valid && id_ready; the head advances at the edge.
//  id_valid = (queue_count != 0). id_pc/id_instr are the registered head entry.
//  Latency: a response accepted at edge t is visible on id_* after t.
//  Capacity: issue is gated on count < DEPTH, and the outstanding slot is reserved at issue,
//    so a push never overflows. Push and pop in the same cycle leave the count unchanged.
//  Redirect (highest priority, same edge):
//    FIFO cleared, queue_count=0, fetch_pc<=redirect_pc, no issue that cycle.
//    WAIT->DROP; DROP stays DROP; IDLE stays IDLE.
//    A response in the same cycle as a redirect is discarded. In WAIT this goes to IDLE, not DROP.
//    A pop in the same cycle is cancelled.
//  Redirect while in DROP: the new target is kept. Issue resumes only after the stale response returns.
//  No combinational path from any input to imem_req/imem_addr except redirect_valid (suppression).
// TESTING
//  1 Reset; memory with L=1, id_ready=1 -> imem_addr 0,4,8,... each 2 cycles; id_pc 0,4,8 in order
//    with matching instr.
//  2 id_ready=0, L=1 -> queue_count climbs to DEPTH=4; imem_req stays low while full; raise id_ready
//    -> 4 pops in order, fetch resumes at 0x10.
//  3 Issue 0x8 with L=3, redirect_pc=0x100 one cycle after issue -> response for 0x8 dropped;
//    next imem_addr=0x100; first id_pc=0x100.
//  4 redirect_valid in the same cycle as imem_rvalid for 0x4 -> nothing pushed; FSM IDLE;
//    next cycle imem_addr=redirect_pc.
//  5 Two redirects (0x200, then 0x300) while in DROP -> only 0x300 fetched after the stale response.
//  6 Assert reset mid-WAIT with a FIFO of 3 entries -> next cycle id_valid=0, queue_count=0,
//    imem_addr=RESET_PC; a late rvalid is ignored.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: owns the PC, keeps one imem request in flight and queues {pc, instr} for decode.
// Response visible on id_* the cycle after it is accepted; fetch stalls while the queue (plus the in-flight slot) is full.
module fetch_prefetch_queue #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter int                    PC_STEP     = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     imem_req,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic                     imem_rvalid,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [ADDR_WIDTH-1:0]    id_pc,
    output logic [INSTR_WIDTH-1:0]   id_instr,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic [ADDR_WIDTH-1:0]  r_req_pc;
    logic [ADDR_WIDTH-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;

    // Reset gates the strobe so memory never sees a request that reset is about to orphan.
    assign w_issue = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH)) && !redirect_valid && !reset;
    assign w_push  = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_pop   = (r_count != '0) && id_ready && !redirect_valid;

    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;
    assign id_valid    = (r_count != '0);
    assign id_pc       = r_pc_mem[r_rd_ptr];
    assign id_instr    = r_instr_mem[r_rd_ptr];
    assign queue_count = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A returning response always frees the slot, even if a redirect arrives with it.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= r_req_pc;
                r_instr_mem[r_wr_ptr] <= imem_rdata;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
